waveform_renderer: RTL and testbench

Multi-channel, parametrised successor to the single-trace ECG plotter. Sits between the VGA timing generator and the VGA pins on the 25 MHz pixel clock. For each pixel column it fetches one packed multi-channel sample word from sample RAM, scales each channel to a screen row, and draws connected traces using vertical fill between adjacent columns. It also supports frame-synchronous scrolling/freeze and a pipeline-matched sync delay.

---
 rtl/waveform_renderer_if.sv | 13 +
 rtl/waveform_renderer.sv | 171 +++++++++++++++++
 tb/tb_waveform_renderer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/waveform_renderer_if.sv
// Sample-RAM read bus between waveform_renderer (master) and the sample store (slave).
// The renderer issues a registered read address. The store returns the packed
// multi-channel word, which the renderer captures on the following clock edge.
interface waveform_renderer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/waveform_renderer.sv
// waveform_renderer: multi-channel connected-trace plotter between the VGA timing
// generator and the VGA pins. It has a three-stage pipeline:
//   S1 registers the address, coordinates and syncs.
//   S2 captures the sample word.
//   S3 registers the colour and syncs.
// Optional feature: define WAVE_GRID_EN to draw a 32-pixel background grid.
module waveform_renderer #(
    parameter int                NCH        = 2,
    parameter int                SW         = 12,
    parameter int                SHIFT      = 4,
    parameter int                BASELINE   = 240,
    parameter int                CH_SPACING = 0,
    parameter int                HEIGHT     = 480,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h801,
    parameter int                WIN_DEPTH  = 1024,
    parameter logic [NCH*12-1:0] CH_COLORS  = {12'hFF0, 12'h0F0}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic              active,
    input  logic              screen_end,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [ADDR_W-1:0] scroll_offset,
    input  logic              freeze,
    waveform_renderer_if.master ram,
    output logic              hSync,
    output logic              vSync,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B
);

    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(WIN_DEPTH - 1);
    localparam logic signed [11:0] ROW_MAX = 12'(HEIGHT - 1);

    logic [ADDR_W-1:0] frame_off;
    logic [ADDR_W-1:0] win_idx;

    logic [9:0]        x1, x2;
    logic [8:0]        y1, y2;
    logic              act1, act2;
    logic              hs1, hs2, vs1, vs2;
    logic [NCH*SW-1:0] smp;
    logic [NCH-1:0]    lit;
    logic [11:0]       rgb;

    // Latch the requested scroll offset once per frame unless frozen.
    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            frame_off <= '0;
        else if (screen_end && !freeze)
            frame_off <= scroll_offset;
    end

    // The window is a power of two, so masking the sum gives the modulo.
    assign win_idx = (ADDR_W'(x) + frame_off) & WIN_MASK;

    // S1: issue the RAM address and delay the coordinates and syncs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ram.rd_addr <= '0;
            x1          <= '0;
            y1          <= '0;
            act1        <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
        end else begin
            ram.rd_addr <= BASE_ADDR + win_idx;
            x1          <= x;
            y1          <= y;
            act1        <= active;
            hs1         <= hsync_in;
            vs1         <= vsync_in;
        end
    end

    // S2: capture the sample word returned for the S1 address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            smp  <= '0;
            x2   <= '0;
            y2   <= '0;
            act2 <= 1'b0;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
        end else begin
            smp  <= ram.rd_data;
            x2   <= x1;
            y2   <= y1;
            act2 <= act1;
            hs2  <= hs1;
            vs2  <= vs1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic signed [11:0] raw;
        logic [11:0]        row_k;
        logic [11:0]        prev_k;
        logic [11:0]        link_k;
        logic [11:0]        lo;
        logic [11:0]        hi;

        // Scale the sample to a screen row and clamp it to the visible rows.
        // NOTE: every path of a combinational block assigns its outputs, so no latch
        // is inferred.
        always_comb begin
            raw = 12'(BASELINE + k * CH_SPACING) - 12'(smp[k*SW +: SW] >> SHIFT);
            if (raw < 12'sd0)
                row_k = '0;
            else if (raw > ROW_MAX)
                row_k = ROW_MAX;
            else
                row_k = raw;
        end

        // Remember this column's row so the next column can draw the link to it.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)
                prev_k <= '0;
            else
                prev_k <= row_k;
        end

        // Column 0 has no left neighbour, so it draws only its own row.
        assign link_k = (x2 == 10'd0) ? row_k : prev_k;
        assign lo     = (link_k < row_k) ? link_k : row_k;
        assign hi     = (link_k < row_k) ? row_k : link_k;
        assign lit[k] = ({3'b000, y2} >= lo) && ({3'b000, y2} <= hi);
    end

    // Choose the pixel colour: lowest lit channel, else background, black when blanked.
    always_comb begin
`ifdef WAVE_GRID_EN
        // The low five coordinate bits act as mod-32 counters restarting at x=0 / y=0.
        rgb = ((x2[4:0] == 5'd0) || (y2[4:0] == 5'd0)) ? 12'h222 : 12'h000;
`else
        rgb = 12'h000;
`endif
        for (int k = NCH - 1; k >= 0; k--) begin
            if (lit[k])
                rgb = CH_COLORS[k*12 +: 12];
        end
        if (!act2)
            rgb = 12'h000;
    end

    // S3: register the colour together with the matching syncs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
            hSync <= 1'b1;
            vSync <= 1'b1;
        end else begin
            VGA_R <= rgb[11:8];
            VGA_G <= rgb[7:4];
            VGA_B <= rgb[3:0];
            hSync <= hs2;
            vSync <= vs2;
        end
    end

endmodule

// File: tb/tb_waveform_renderer.sv
// Directed testbench for waveform_renderer in its default configuration:
// two channels, CH_SPACING=0, grid disabled.
// The sample RAM is modelled as an array read through the interface. Each pixel's
// expected {RGB, hSync, vSync} is queued and compared three cycles after it is driven.
module tb_waveform_renderer;

    localparam int AW = 12;
    localparam int DW = 24;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       active = 1'b0;
    logic       screen_end = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       freeze = 1'b0;
    logic [AW-1:0] scroll_offset = '0;
    logic       hSync, vSync;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    logic [DW-1:0] mem [0:4095];

    int asserts = 0;
    int fails   = 0;
    int pix_id  = 0;

    typedef struct {
        logic [13:0] exp;
        int          id;
    } exp_t;
    exp_t q[$];

    always #20 clock = ~clock;

    waveform_renderer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    assign bus.rd_data = mem[bus.rd_addr];

    waveform_renderer dut (
        .clock         (clock),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .active        (active),
        .screen_end    (screen_end),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .scroll_offset (scroll_offset),
        .freeze        (freeze),
        .ram           (bus),
        .hSync         (hSync),
        .vSync         (vSync),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel for one cycle and check the output of the pixel driven 3 cycles ago.
    task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic pact,
                       input logic phs, input logic pvs, input logic [11:0] prgb);
        exp_t e;
        if (q.size() == 3) begin
            e = q.pop_front();
            check($sformatf("pixel%0d", e.id), {18'd0, VGA_R, VGA_G, VGA_B, hSync, vSync}, {18'd0, e.exp});
        end
        x        = px;
        y        = py;
        active   = pact;
        hsync_in = phs;
        vsync_in = pvs;
        q.push_back('{exp: {prgb, phs, pvs}, id: pix_id});
        pix_id++;
        @(negedge clock);
    endtask

    // Drain the outstanding expectations while driving a blanked pixel.
    task automatic flush();
        exp_t e;
        active   = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        while (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("pixel%0d", e.id), {18'd0, VGA_R, VGA_G, VGA_B, hSync, vSync}, {18'd0, e.exp});
            @(negedge clock);
        end
    endtask

    task automatic addr_at(input string tag, input logic [9:0] px, input logic [AW-1:0] exp);
        x = px;
        @(negedge clock);
        check(tag, {20'd0, bus.rd_addr}, {20'd0, exp});
    endtask

    task automatic frame_pulse();
        screen_end = 1'b1;
        @(negedge clock);
        screen_end = 1'b0;
    endtask

    initial begin
        // Default samples: ch0 = 0x100 -> row 224, ch1 = 0xC80 -> row 40.
        for (int i = 0; i < 4096; i++) mem[i] = {12'hC80, 12'h100};
        mem[12'h80B] = {12'hC80, 12'h000};   // x=10: ch0 row 240
        mem[12'h80C] = {12'hC80, 12'h500};   // x=11: ch0 row 160
        mem[12'h80D] = {12'h100, 12'h100};   // x=12: both channels row 224
        mem[12'h80E] = {12'hC80, 12'hFFF};   // x=13: ch0 clamps to row 0

        // Reset held with random inputs.
        for (int r = 0; r < 2; r++) begin
            repeat (2) begin
                @(negedge clock);
                x             = 10'($urandom);
                y             = 9'($urandom);
                active        = 1'($urandom);
                hsync_in      = 1'($urandom);
                vsync_in      = 1'($urandom);
                screen_end    = 1'($urandom);
                scroll_offset = 12'($urandom);
            end
            check("rst_rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
            check("rst_hsync", {31'd0, hSync}, 32'd1);
            check("rst_vsync", {31'd0, vSync}, 32'd1);
            check("rst_rd_addr", {20'd0, bus.rd_addr}, 32'd0);
        end

        // A lit, active pixel right before release must never appear.
        @(negedge clock);
        screen_end    = 1'b0;
        scroll_offset = '0;
        x             = 10'd5;
        y             = 9'd224;
        active        = 1'b1;
        hsync_in      = 1'b0;
        vsync_in      = 1'b0;
        @(negedge clock);

        // Release mid-frame: three cycles of black with idle syncs precede the first pixel.
        for (int i = 0; i < 3; i++) begin
            q.push_back('{exp: {12'h000, 1'b1, 1'b1}, id: pix_id});
            pix_id++;
        end
        reset = 1'b1;

        // Flat trace, sync alignment, blanking.
        pix(10'd0, 9'd224, 1'b1, 1'b0, 1'b1, 12'h0F0);
        pix(10'd5, 9'd224, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd6, 9'd223, 1'b1, 1'b1, 1'b0, 12'h000);
        pix(10'd7, 9'd40,  1'b1, 1'b1, 1'b1, 12'hFF0);
        pix(10'd8, 9'd225, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd9, 9'd224, 1'b0, 1'b1, 1'b1, 12'h000);

        // Vertical fill: column 10 row 240, column 11 row 160; column 0 isolated.
        pix(10'd0, 9'd159, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd10, 9'd159, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd11, 9'd159, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd0, 9'd160, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd10, 9'd160, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd11, 9'd160, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd0, 9'd200, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd10, 9'd200, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd11, 9'd200, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd0, 9'd224, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd10, 9'd224, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd11, 9'd224, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd0, 9'd240, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd10, 9'd240, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd11, 9'd240, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd0, 9'd241, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd10, 9'd241, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd11, 9'd241, 1'b1, 1'b1, 1'b1, 12'h000);

        // Priority (both channels on row 224 at x=12) and clamp (0xFFF -> row 0 at x=13).
        pix(10'd0, 9'd224, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd12, 9'd224, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd13, 9'd224, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd0, 9'd100, 1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd12, 9'd100, 1'b1, 1'b1, 1'b1, 12'hFF0);
        pix(10'd13, 9'd100, 1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd0, 9'd0,   1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd12, 9'd0,  1'b1, 1'b1, 1'b1, 12'h000);
        pix(10'd13, 9'd0,  1'b1, 1'b1, 1'b1, 12'h0F0);
        pix(10'd0, 9'd40,  1'b1, 1'b1, 1'b1, 12'hFF0);
        pix(10'd12, 9'd40, 1'b1, 1'b1, 1'b1, 12'hFF0);
        pix(10'd13, 9'd40, 1'b1, 1'b1, 1'b1, 12'h0F0);
        flush();

        // Scroll: a mid-frame request waits for screen_end, then the window wraps.
        scroll_offset = 12'd1000;
        addr_at("addr_before_frame_end", 10'd30, 12'h81F);
        frame_pulse();
        addr_at("addr_scrolled", 10'd30, 12'h807);
        addr_at("addr_window_last", 10'd23, 12'hC00);
        addr_at("addr_window_wrap", 10'd24, 12'h801);

        // Freeze wins over screen_end.
        freeze        = 1'b1;
        scroll_offset = 12'd5;
        frame_pulse();
        addr_at("addr_frozen", 10'd30, 12'h807);
        freeze = 1'b0;
        frame_pulse();
        addr_at("addr_unfrozen", 10'd30, 12'h824);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
